// File: rtl/disp_reg_responder_if.sv
// disp_reg_responder_if: write/read channel bundle between the dispatch decoder (master) and a register responder (slave)
//   iWriteAddress/iWriteData/iWriteValid -> write request, oWriteAck <- one-cycle write acknowledge
//   iReadAddress/iReadValid -> read request, oReadData/oReadAck <- read data and one-cycle acknowledge
interface disp_reg_responder_if;
    logic [31:0] iWriteAddress;
    logic [31:0] iWriteData;
    logic        iWriteValid;
    logic        oWriteAck;
    logic [31:0] iReadAddress;
    logic [31:0] oReadData;
    logic        iReadValid;
    logic        oReadAck;
    modport master (
        output iWriteAddress, iWriteData, iWriteValid, iReadAddress, iReadValid,
        input  oWriteAck, oReadData, oReadAck
    );
    modport slave (
        input  iWriteAddress, iWriteData, iWriteValid, iReadAddress, iReadValid,
        output oWriteAck, oReadData, oReadAck
    );
endinterface

// File: rtl/disp_reg_responder.sv
// disp_reg_responder: register-bank responder answering decoder write/read channels after a fixed latency
//   iClock, iReset  clock and synchronous active-high reset
//   bus             disp_reg_responder_if.slave write/read channels
//   oRegs           flattened RW register contents, reg i at [32i+31:32i]
//   iStatus         live status word, read at 0xFF8
//   iEvent          event pulses OR-ed into the sticky event register (0xFF4, write-1-to-clear)
//   oIrq            registered OR of event & mask (mask at 0xFEC)
// Optional: define DISP_RESP_ERRCNT_EN for a saturating unmapped-access counter at 0xFF0.
module disp_reg_responder #(
    parameter int          NumRegs    = 16,
    parameter int          AckLatency = 1,
    parameter logic [31:0] IdValue    = 32'h0000_0001
) (
    input  logic                    iClock,
    input  logic                    iReset,
    disp_reg_responder_if.slave     bus,
    output logic [32*NumRegs-1:0]   oRegs,
    input  logic [31:0]             iStatus,
    input  logic [31:0]             iEvent,
    output logic                    oIrq
);
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ACK, S_RELEASE} state_t;
    localparam logic [9:0] IdxMask   = 10'h3FB;
    localparam logic [9:0] IdxErrCnt = 10'h3FC;
    localparam logic [9:0] IdxEvent  = 10'h3FD;
    localparam logic [9:0] IdxStatus = 10'h3FE;
    localparam logic [9:0] IdxId     = 10'h3FF;
`ifdef DISP_RESP_ERRCNT_EN
    localparam bit HasErrCnt = 1'b1;
`else
    localparam bit HasErrCnt = 1'b0;
`endif
    state_t      r_wr_state, w_wr_next, r_rd_state, w_rd_next;
    logic [3:0]  r_wr_cnt, w_wr_cnt_next, r_rd_cnt, w_rd_cnt_next;
    logic [31:0] r_regs [NumRegs];
    logic [31:0] r_mask, r_event, w_rd_val, w_clear;
    logic        r_irq, w_wr_commit, w_rd_ack;
    logic [9:0]  w_wr_idx, w_rd_idx;
    logic        w_unused;

    function automatic logic f_mapped(input logic [9:0] idx);
        f_mapped = idx < 10'(NumRegs) || idx == IdxMask || idx >= IdxEvent || (HasErrCnt && idx == IdxErrCnt);
    endfunction

    assign w_wr_idx    = bus.iWriteAddress[11:2];
    assign w_rd_idx    = bus.iReadAddress[11:2];
    assign w_wr_commit = r_wr_state == S_ACK;
    assign w_rd_ack    = r_rd_state == S_ACK;
    assign w_unused    = &{1'b0, bus.iWriteAddress[31:12], bus.iWriteAddress[1:0],
                           bus.iReadAddress[31:12], bus.iReadAddress[1:0]};

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_wr_state <= S_IDLE;
            r_rd_state <= S_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
            r_wr_cnt   <= w_wr_cnt_next;
            r_rd_cnt   <= w_rd_cnt_next;
        end
    end

    // Counter is loaded with AckLatency-1 on accept and reaches zero as ACK is entered,
    // so ack lands exactly AckLatency cycles after the first valid cycle.
    always_comb begin
        w_wr_next     = r_wr_state;
        w_wr_cnt_next = r_wr_cnt;
        case (r_wr_state)
            S_IDLE: if (bus.iWriteValid) begin
                w_wr_cnt_next = 4'(AckLatency - 1);
                w_wr_next     = AckLatency == 1 ? S_ACK : S_COUNT;
            end
            S_COUNT: begin
                w_wr_cnt_next = r_wr_cnt - 4'd1;
                w_wr_next     = !bus.iWriteValid ? S_IDLE : r_wr_cnt == 4'd1 ? S_ACK : S_COUNT;
            end
            S_ACK:     w_wr_next = S_RELEASE;
            S_RELEASE: w_wr_next = bus.iWriteValid ? S_RELEASE : S_IDLE;
            default:   w_wr_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_next     = r_rd_state;
        w_rd_cnt_next = r_rd_cnt;
        case (r_rd_state)
            S_IDLE: if (bus.iReadValid) begin
                w_rd_cnt_next = 4'(AckLatency - 1);
                w_rd_next     = AckLatency == 1 ? S_ACK : S_COUNT;
            end
            S_COUNT: begin
                w_rd_cnt_next = r_rd_cnt - 4'd1;
                w_rd_next     = !bus.iReadValid ? S_IDLE : r_rd_cnt == 4'd1 ? S_ACK : S_COUNT;
            end
            S_ACK:     w_rd_next = S_RELEASE;
            S_RELEASE: w_rd_next = bus.iReadValid ? S_RELEASE : S_IDLE;
            default:   w_rd_next = S_IDLE;
        endcase
    end

    // Event clear only applies in the commit cycle; a same-cycle iEvent bit re-sets it.
    assign w_clear = (w_wr_commit && w_wr_idx == IdxEvent) ? bus.iWriteData : 32'h0;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_regs  <= '{default: '0};
            r_mask  <= '0;
            r_event <= '0;
            r_irq   <= 1'b0;
        end else begin
            for (int k = 0; k < NumRegs; k++)
                if (w_wr_commit && w_wr_idx == 10'(k)) r_regs[k] <= bus.iWriteData;
            if (w_wr_commit && w_wr_idx == IdxMask) r_mask <= bus.iWriteData;
            r_event <= (r_event & ~w_clear) | iEvent;
            r_irq   <= |(r_event & r_mask);
        end
    end

`ifdef DISP_RESP_ERRCNT_EN
    logic [15:0] r_errcnt;
    logic [16:0] w_err_sum;
    assign w_err_sum = 17'(r_errcnt) + 17'(w_rd_ack && !f_mapped(w_rd_idx))
                     + 17'(w_wr_commit && !f_mapped(w_wr_idx));
    always_ff @(posedge iClock) begin
        if (iReset || (w_wr_commit && w_wr_idx == IdxErrCnt)) r_errcnt <= '0;
        else r_errcnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
`endif

    // Read data comes from current contents, so a same-cycle write commit is not yet visible.
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NumRegs; k++)
            if (w_rd_idx == 10'(k)) w_rd_val = r_regs[k];
        if (w_rd_idx == IdxMask)   w_rd_val = r_mask;
        if (w_rd_idx == IdxEvent)  w_rd_val = r_event;
        if (w_rd_idx == IdxStatus) w_rd_val = iStatus;
        if (w_rd_idx == IdxId)     w_rd_val = IdValue;
`ifdef DISP_RESP_ERRCNT_EN
        if (w_rd_idx == IdxErrCnt) w_rd_val = {16'h0, r_errcnt};
`endif
    end

    for (genvar i = 0; i < NumRegs; i++) begin : g_regs
        assign oRegs[32*i +: 32] = r_regs[i];
    end

    assign bus.oWriteAck = w_wr_commit;
    assign bus.oReadAck  = w_rd_ack;
    assign bus.oReadData = w_rd_ack ? w_rd_val : 32'h0;
    assign oIrq          = r_irq;
endmodule

// File: tb/tb_disp_reg_responder.sv
// tb_disp_reg_responder: directed self-checking bench for disp_reg_responder (NumRegs=16, AckLatency=3)
module tb_disp_reg_responder;
    localparam logic [31:0] Id = 32'h1234_5678;
    logic           iClock = 0;
    logic           iReset = 1;
    logic [511:0]   oRegs;
    logic [31:0]    iStatus = 32'hA5A5_0F0F;
    logic [31:0]    iEvent = 0;
    logic           oIrq;
    int             checks = 0;
    int             fails = 0;

    disp_reg_responder_if bus();

    disp_reg_responder #(.NumRegs(16), .AckLatency(3), .IdValue(Id)) dut (
        .iClock(iClock), .iReset(iReset), .bus(bus.slave),
        .oRegs(oRegs), .iStatus(iStatus), .iEvent(iEvent), .oIrq(oIrq)
    );

    always #5 iClock = ~iClock;

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int lat, output logic [511:0] snap);
        @(posedge iClock); #1;
        bus.iWriteAddress = a;
        bus.iWriteData = d;
        bus.iWriteValid = 1;
        lat = -1;
        snap = 'x;
        for (int n = 0; n < 20; n++) begin
            @(negedge iClock);
            if (bus.oWriteAck) begin
                lat = n;
                snap = oRegs;
                break;
            end
        end
        @(posedge iClock); #1;
        bus.iWriteValid = 0;
    endtask

    task automatic rd(input logic [31:0] a, output int lat, output logic [31:0] d);
        @(posedge iClock); #1;
        bus.iReadAddress = a;
        bus.iReadValid = 1;
        lat = -1;
        d = 32'hDEAD_DEAD;
        for (int n = 0; n < 20; n++) begin
            @(negedge iClock);
            if (bus.oReadAck) begin
                lat = n;
                d = bus.oReadData;
                break;
            end
        end
        @(posedge iClock); #1;
        bus.iReadValid = 0;
    endtask

    task automatic test_reset;
        int lat;
        logic [31:0] d;
        repeat (3) @(negedge iClock);
        checks++; if (bus.oWriteAck !== 1'b0 || bus.oReadAck !== 1'b0) begin fails++; $display("FAIL reset_acks: wr=%b rd=%b required 0 0", bus.oWriteAck, bus.oReadAck); end
        checks++; if (bus.oReadData !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h required 0", bus.oReadData); end
        checks++; if (oRegs !== 512'h0) begin fails++; $display("FAIL reset_regs: got nonzero %h required 0", oRegs[63:0]); end
        checks++; if (oIrq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b required 0", oIrq); end
        @(posedge iClock); #1 iReset = 0;
        rd(32'h000, lat, d);
        checks++; if (lat !== 3 || d !== 32'h0) begin fails++; $display("FAIL rd_reg0: lat %0d data %h required lat 3 data 0", lat, d); end
        rd(32'hFF8, lat, d);
        checks++; if (d !== 32'hA5A5_0F0F) begin fails++; $display("FAIL rd_status: got %h required a5a50f0f", d); end
        rd(32'hFFC, lat, d);
        checks++; if (d !== Id) begin fails++; $display("FAIL rd_id: got %h required %h", d, Id); end
        checks++; if (oIrq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b required 0", oIrq); end
    endtask

    task automatic test_write;
        int lat;
        logic [511:0] snap;
        logic [31:0] d;
        wr(32'h004, 32'hCAFE_F00D, lat, snap);
        checks++; if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d required 3", lat); end
        checks++; if (snap[63:32] !== 32'h0) begin fails++; $display("FAIL wr_not_early: got %h required 0 during ack", snap[63:32]); end
        checks++; if (oRegs[63:32] !== 32'hCAFE_F00D) begin fails++; $display("FAIL wr_commit: got %h required cafef00d", oRegs[63:32]); end
        rd(32'h004, lat, d);
        checks++; if (d !== 32'hCAFE_F00D) begin fails++; $display("FAIL wr_readback: got %h required cafef00d", d); end
        rd(32'h1234_5005, lat, d);
        checks++; if (d !== 32'hCAFE_F00D) begin fails++; $display("FAIL addr_alias: got %h required cafef00d", d); end
        iStatus = 32'h0BAD_BEEF;
        rd(32'hFF8, lat, d);
        checks++; if (d !== 32'h0BAD_BEEF) begin fails++; $display("FAIL status_live: got %h required 0badbeef", d); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, acks;
        logic [511:0] snap;
        wr(32'h008, 32'h1111_1111, lat1, snap);
        wr(32'h00C, 32'h2222_2222, lat2, snap);
        checks++; if (lat1 !== 3 || lat2 !== 3) begin fails++; $display("FAIL b2b_latency: got %0d %0d required 3 3", lat1, lat2); end
        checks++; if (oRegs[127:64] !== 64'h2222_2222_1111_1111) begin fails++; $display("FAIL b2b_commit: got %h required 2222222211111111", oRegs[127:64]); end
        @(posedge iClock); #1;
        bus.iWriteAddress = 32'h008;
        bus.iWriteData = 32'h3333_3333;
        bus.iWriteValid = 1;
        acks = 0;
        for (int n = 0; n < 5; n++) begin @(negedge iClock); acks += int'(bus.oWriteAck); end
        @(posedge iClock); #1 bus.iWriteData = 32'h4444_4444;
        for (int n = 0; n < 5; n++) begin @(negedge iClock); acks += int'(bus.oWriteAck); end
        checks++; if (acks !== 1) begin fails++; $display("FAIL linger_acks: got %0d required 1", acks); end
        checks++; if (oRegs[95:64] !== 32'h3333_3333) begin fails++; $display("FAIL linger_commit: got %h required 33333333", oRegs[95:64]); end
        @(posedge iClock); #1 bus.iWriteValid = 0;
        wr(32'h008, 32'h5555_5555, lat1, snap);
        checks++; if (lat1 !== 3 || oRegs[95:64] !== 32'h5555_5555) begin fails++; $display("FAIL after_linger: lat %0d data %h required 3 55555555", lat1, oRegs[95:64]); end
    endtask

    task automatic test_event;
        int lat;
        logic [511:0] snap;
        logic [31:0] d;
        wr(32'hFEC, 32'h20, lat, snap);
        @(posedge iClock); #1 iEvent = 32'h20;
        @(posedge iClock); #1 iEvent = 0;
        @(negedge iClock);
        checks++; if (oIrq !== 1'b0) begin fails++; $display("FAIL irq_delay: got %b required 0", oIrq); end
        @(negedge iClock);
        checks++; if (oIrq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b required 1", oIrq); end
        @(posedge iClock); #1;
        bus.iWriteAddress = 32'hFF4;
        bus.iWriteData = 32'h20;
        bus.iWriteValid = 1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge iClock);
            if (bus.oWriteAck) begin lat = n; iEvent = 32'h20; break; end
        end
        @(posedge iClock); #1;
        bus.iWriteValid = 0;
        iEvent = 0;
        checks++; if (lat !== 3) begin fails++; $display("FAIL w1c_ack: got %0d required 3", lat); end
        rd(32'hFF4, lat, d);
        checks++; if (d !== 32'h20 || oIrq !== 1'b1) begin fails++; $display("FAIL set_wins: event %h irq %b required 20 1", d, oIrq); end
        wr(32'hFF4, 32'h20, lat, snap);
        @(negedge iClock);
        checks++; if (oIrq !== 1'b1) begin fails++; $display("FAIL irq_clear_delay: got %b required 1", oIrq); end
        @(negedge iClock);
        checks++; if (oIrq !== 1'b0) begin fails++; $display("FAIL irq_cleared: got %b required 0", oIrq); end
    endtask

    task automatic test_unmapped;
        int lat;
        logic [511:0] snap;
        logic [31:0] d, exp_cnt;
`ifdef DISP_RESP_ERRCNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        rd(32'h800, lat, d);
        checks++; if (lat !== 3 || d !== 32'h0) begin fails++; $display("FAIL unmapped_rd: lat %0d data %h required 3 0", lat, d); end
        wr(32'h900, 32'hFFFF_FFFF, lat, snap);
        checks++; if (lat !== 3 || oRegs !== snap) begin fails++; $display("FAIL unmapped_wr: lat %0d required 3, regs changed %b", lat, oRegs !== snap); end
        rd(32'hFF0, lat, d);
        checks++; if (d !== exp_cnt) begin fails++; $display("FAIL errcnt: got %h required %h", d, exp_cnt); end
        wr(32'hFFC, 32'h0, lat, snap);
        rd(32'hFFC, lat, d);
        checks++; if (d !== Id) begin fails++; $display("FAIL ro_id_write: got %h required %h", d, Id); end
    endtask

    task automatic test_reset_abort;
        int acks;
        @(posedge iClock); #1;
        bus.iWriteAddress = 32'h000;
        bus.iWriteData = 32'hDEAD_BEEF;
        bus.iWriteValid = 1;
        acks = 0;
        repeat (2) begin @(negedge iClock); acks += int'(bus.oWriteAck); end
        iReset = 1;
        bus.iWriteValid = 0;
        repeat (2) begin @(negedge iClock); acks += int'(bus.oWriteAck); end
        iReset = 0;
        repeat (5) begin @(negedge iClock); acks += int'(bus.oWriteAck); end
        checks++; if (acks !== 0) begin fails++; $display("FAIL abort_ack: got %0d acks required 0", acks); end
        checks++; if (oRegs[63:0] !== 64'h0) begin fails++; $display("FAIL abort_regs: got %h required 0", oRegs[63:0]); end
    endtask

    initial begin
        bus.iWriteAddress = 0;
        bus.iWriteData = 0;
        bus.iWriteValid = 0;
        bus.iReadAddress = 0;
        bus.iReadValid = 0;
        test_reset;
        test_write;
        test_back_to_back;
        test_event;
        test_unmapped;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
